// File: rtl/calc_engine.sv
// Multi-cycle calculator core: single-step ALU ops plus iterative shift-add MUL
// and restoring DIV, under a start/busy/done handshake with held outputs.
module calc_engine #(
    parameter int unsigned WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [2:0]       op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] result,
    output logic [WIDTH-1:0] result_hi,
    output logic             carry,
    output logic             ovf,
    output logic             zero,
    output logic             dbz
);
    localparam int unsigned CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam int unsigned PW = 2 * WIDTH;

    localparam logic [2:0] OP_ADD = 3'd0;
    localparam logic [2:0] OP_SUB = 3'd1;
    localparam logic [2:0] OP_MUL = 3'd2;
    localparam logic [2:0] OP_DIV = 3'd3;
    localparam logic [2:0] OP_AND = 3'd4;
    localparam logic [2:0] OP_OR  = 3'd5;
    localparam logic [2:0] OP_XOR = 3'd6;
    localparam logic [2:0] OP_CMP = 3'd7;

    typedef enum logic [1:0] {
        S_IDLE,
        S_EXEC,
        S_ITER,
        S_FIN
    } state_e;

    state_e           state_q, state_d;
    logic [2:0]       op_q, op_d;
    logic [WIDTH-1:0] a_q, a_d, b_q, b_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic [PW-1:0]    p_q, p_d;

    // Staged EXEC results, published to the outputs on the FIN edge
    logic [WIDTH-1:0] s_res_q, s_res_d, s_hi_q, s_hi_d;
    logic             s_carry_q, s_carry_d, s_ovf_q, s_ovf_d, s_dbz_q, s_dbz_d;

    logic             busy_q, busy_d, done_q, done_d;
    logic [WIDTH-1:0] result_q, result_d, result_hi_q, result_hi_d;
    logic             carry_q, carry_d, ovf_q, ovf_d, zero_q, zero_d, dbz_q, dbz_d;

    logic [WIDTH:0]   add_w, sub_w, mul_sum, div_sh, div_diff;
    logic             div_ge;

    // p_q holds {acc, multiplier} for MUL and {remainder, dividend/quotient} for DIV
    assign add_w    = {1'b0, a_q} + {1'b0, b_q};
    assign sub_w    = {1'b0, a_q} - {1'b0, b_q};
    assign mul_sum  = {1'b0, p_q[PW-1:WIDTH]} + (p_q[0] ? {1'b0, a_q} : '0);
    assign div_sh   = {p_q[PW-1:WIDTH], p_q[WIDTH-1]};
    assign div_diff = div_sh - {1'b0, b_q};
    assign div_ge   = ~div_diff[WIDTH];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= S_IDLE;
            op_q        <= '0;
            a_q         <= '0;
            b_q         <= '0;
            cnt_q       <= '0;
            p_q         <= '0;
            s_res_q     <= '0;
            s_hi_q      <= '0;
            s_carry_q   <= 1'b0;
            s_ovf_q     <= 1'b0;
            s_dbz_q     <= 1'b0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            result_q    <= '0;
            result_hi_q <= '0;
            carry_q     <= 1'b0;
            ovf_q       <= 1'b0;
            zero_q      <= 1'b0;
            dbz_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            op_q        <= op_d;
            a_q         <= a_d;
            b_q         <= b_d;
            cnt_q       <= cnt_d;
            p_q         <= p_d;
            s_res_q     <= s_res_d;
            s_hi_q      <= s_hi_d;
            s_carry_q   <= s_carry_d;
            s_ovf_q     <= s_ovf_d;
            s_dbz_q     <= s_dbz_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
            result_q    <= result_d;
            result_hi_q <= result_hi_d;
            carry_q     <= carry_d;
            ovf_q       <= ovf_d;
            zero_q      <= zero_d;
            dbz_q       <= dbz_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        op_d        = op_q;
        a_d         = a_q;
        b_d         = b_q;
        cnt_d       = cnt_q;
        p_d         = p_q;
        s_res_d     = s_res_q;
        s_hi_d      = s_hi_q;
        s_carry_d   = s_carry_q;
        s_ovf_d     = s_ovf_q;
        s_dbz_d     = s_dbz_q;
        busy_d      = busy_q;
        done_d      = 1'b0;
        result_d    = result_q;
        result_hi_d = result_hi_q;
        carry_d     = carry_q;
        ovf_d       = ovf_q;
        zero_d      = zero_q;
        dbz_d       = dbz_q;

        unique case (state_q)
            S_IDLE: begin
                if (start) begin
                    op_d   = op;
                    a_d    = a;
                    b_d    = b;
                    cnt_d  = '0;
                    busy_d = 1'b1;
                    p_d    = (op == OP_MUL) ? {{WIDTH{1'b0}}, b} : {{WIDTH{1'b0}}, a};
                    if (op == OP_MUL || (op == OP_DIV && b != '0)) begin
                        state_d = S_ITER;
                    end else begin
                        state_d = S_EXEC;
                    end
                end
            end

            S_ITER: begin
                if (op_q == OP_MUL) begin
                    p_d = {mul_sum, p_q[WIDTH-1:1]};
                end else begin
                    p_d = {(div_ge ? div_diff[WIDTH-1:0] : div_sh[WIDTH-1:0]),
                           p_q[WIDTH-2:0], div_ge};
                end
                cnt_d = cnt_q + CW'(1);
                if (cnt_q == CW'(WIDTH - 1)) begin
                    cnt_d   = '0;
                    state_d = S_EXEC;
                end
            end

            S_EXEC: begin
                s_hi_d    = '0;
                s_carry_d = 1'b0;
                s_ovf_d   = 1'b0;
                s_dbz_d   = 1'b0;
                unique case (op_q)
                    OP_ADD: begin
                        s_res_d   = add_w[WIDTH-1:0];
                        s_carry_d = add_w[WIDTH];
                        s_ovf_d   = (a_q[WIDTH-1] == b_q[WIDTH-1]) &&
                                    (add_w[WIDTH-1] != a_q[WIDTH-1]);
                    end
                    OP_SUB: begin
                        s_res_d   = sub_w[WIDTH-1:0];
                        s_carry_d = sub_w[WIDTH];
                        s_ovf_d   = (a_q[WIDTH-1] != b_q[WIDTH-1]) &&
                                    (sub_w[WIDTH-1] != a_q[WIDTH-1]);
                    end
                    OP_MUL: begin
                        s_res_d = p_q[WIDTH-1:0];
                        s_hi_d  = p_q[PW-1:WIDTH];
                        s_ovf_d = (p_q[PW-1:WIDTH] != '0);
                    end
                    OP_DIV: begin
                        if (b_q == '0) begin
                            s_res_d = '1;
                            s_hi_d  = a_q;
                            s_dbz_d = 1'b1;
                        end else begin
                            s_res_d = p_q[WIDTH-1:0];
                            s_hi_d  = p_q[PW-1:WIDTH];
                        end
                    end
                    OP_AND: s_res_d = a_q & b_q;
                    OP_OR:  s_res_d = a_q | b_q;
                    OP_XOR: s_res_d = a_q ^ b_q;
                    OP_CMP: begin
                        s_res_d = WIDTH'(a_q < b_q);
                        s_hi_d  = WIDTH'(a_q == b_q);
                    end
                    default: s_res_d = '0;
                endcase
                state_d = S_FIN;
            end

            S_FIN: begin
                result_d    = s_res_q;
                result_hi_d = s_hi_q;
                carry_d     = s_carry_q;
                ovf_d       = s_ovf_q;
                dbz_d       = s_dbz_q;
                zero_d      = (s_res_q == '0);
                done_d      = 1'b1;
                busy_d      = 1'b0;
                state_d     = S_IDLE;
            end

            default: state_d = S_IDLE;
        endcase
    end

    assign busy      = busy_q;
    assign done      = done_q;
    assign result    = result_q;
    assign result_hi = result_hi_q;
    assign carry     = carry_q;
    assign ovf       = ovf_q;
    assign zero      = zero_q;
    assign dbz       = dbz_q;

endmodule
